sync_fifo: RTL and testbench

- Single-clock synchronous FIFO, 8-bit data, 32 entries.
- Buffers bytes between a producer (wr/data_in) and a consumer (rd/data_out).
- Provides full/empty status and one-cycle overflow/underflow error pulses for illegal accesses.

---
 rtl/sync_fifo.sv | 139 +++++++++++++
 tb/tb_sync_fifo.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
//
// Single-clock synchronous FIFO. Bytes are buffered between a producer that
// drives wr/data_in and a consumer that drives rd and receives data_out.
// full/empty are decoded from an occupancy counter. Illegal accesses produce
// one-cycle overflow/underflow pulses.
//
// Optional feature (compile-time macro FIFO_COUNT_EN):
//   defined   -> adds output port 'count', the live occupancy counter
//   undefined -> no count port; all other behaviour is identical
//
// Ports:
//   clk        in   1            rising-edge clock
//   rst        in   1            asynchronous active-high reset
//   wr         in   1            write request, sampled on rising clk
//   rd         in   1            read request, sampled on rising clk
//   data_in    in   DATA_WIDTH   write data, captured on an accepted write
//   data_out   out  DATA_WIDTH   registered read data, holds between reads
//   full       out  1            occupancy == DEPTH
//   empty      out  1            occupancy == 0
//   overflow   out  1            registered pulse for a rejected write
//   underflow  out  1            registered pulse for a rejected read
//   count      out  ADDR_WIDTH+1 occupancy (only with FIFO_COUNT_EN)
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 32,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  overflow,
  output logic                  underflow
`ifdef FIFO_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]   count
`endif
);

  localparam logic [ADDR_WIDTH:0] FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   occupancy;
  logic                  rd_accept;
  logic                  wr_accept;

  // Status flags decode straight from the counter so they move on the same
  // edge the counter does.
  assign full  = (occupancy == FULL_COUNT);
  assign empty = (occupancy == '0);

  // A write into a full FIFO is still legal when a read frees a slot on the
  // same edge. When full, wr_ptr == rd_ptr, so the read fetches the old word
  // before the write overwrites that location (non-blocking semantics).
  assign rd_accept = rd & ~empty;
  assign wr_accept = wr & (~full | rd_accept);

  // Storage is deliberately not reset; stale words are unreachable because
  // the pointers and counter are cleared.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // DEPTH is a power of two, so natural pointer rollover is the wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (rd_accept) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
    end
  end

  // Occupancy counts only accepted accesses; a matched read/write pair
  // leaves it unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
    end else begin
      case ({wr_accept, rd_accept})
        2'b10:   occupancy <= occupancy + (ADDR_WIDTH + 1)'(1);
        2'b01:   occupancy <= occupancy - (ADDR_WIDTH + 1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Read data is registered and held until the next accepted read. There is
  // no write-to-read bypass, even when the FIFO is empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
    end else if (rd_accept) begin
      data_out <= mem[rd_ptr];
    end
  end

  // Error pulses are registered versions of the rejection conditions, so
  // they appear for one cycle after each offending request cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wr & full & ~rd;
      underflow <= rd & empty;
    end
  end

`ifdef FIFO_COUNT_EN
  assign count = occupancy;
`endif

`ifndef SYNTHESIS
  // Internal consistency checks.
  occupancy_in_range : assert property (@(posedge clk) disable iff (rst)
    occupancy <= FULL_COUNT);

  flags_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(full && empty));
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo
//
// Directed testbench for sync_fifo. Stimulus tasks drive one request per
// cycle and push the hand-computed post-edge expectation into a queue; an
// independent monitor pops one entry after every rising edge and compares.
// -----------------------------------------------------------------------------
module tb_sync_fifo;

  typedef struct {
    string      tag;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       udf;
    logic [5:0] cnt;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       wr;
  logic       rd;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       underflow;
`ifdef FIFO_COUNT_EN
  logic [5:0] count;
`endif

  exp_t exp_q[$];
  int   compared;
  int   mismatched;

  sync_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (32),
    .ADDR_WIDTH (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .wr        (wr),
    .rd        (rd),
    .data_in   (data_in),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
`ifdef FIFO_COUNT_EN
    ,
    .count     (count)
`endif
  );

  // 10 ns clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one field and record the result.
  task automatic checkField(input string tag, input string field,
                            input logic [7:0] act, input logic [7:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s.%s: got 0x%0h, expected 0x%0h", tag, field, act, expv);
    end
  endtask

  // Compare all visible outputs against one expectation record.
  task automatic checkOutput(input exp_t x);
    checkField(x.tag, "data_out",  data_out,        x.dout);
    checkField(x.tag, "full",      {7'd0, full},      {7'd0, x.full});
    checkField(x.tag, "empty",     {7'd0, empty},     {7'd0, x.empty});
    checkField(x.tag, "overflow",  {7'd0, overflow},  {7'd0, x.ovf});
    checkField(x.tag, "underflow", {7'd0, underflow}, {7'd0, x.udf});
`ifdef FIFO_COUNT_EN
    checkField(x.tag, "count",     {2'd0, count},     {2'd0, x.cnt});
`endif
  endtask

  // Drive one request cycle and queue what the outputs must be after the
  // rising edge that samples it.
  task automatic applyStimulus(input string tag, input logic w, input logic r,
                               input logic [7:0] din, input logic [7:0] dout,
                               input logic f, input logic e, input logic ov,
                               input logic un, input logic [5:0] cnt);
    exp_t x;
    @(negedge clk);
    wr      = w;
    rd      = r;
    data_in = din;
    x.tag   = tag;
    x.dout  = dout;
    x.full  = f;
    x.empty = e;
    x.ovf   = ov;
    x.udf   = un;
    x.cnt   = cnt;
    exp_q.push_back(x);
  endtask

  // Monitor: one expectation per rising edge, sampled 1 ns after the edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        x = exp_q.pop_front();
        checkOutput(x);
      end
    end
  end

  // Reset-state expectation used for the direct asynchronous checks.
  function automatic exp_t resetExp(input string tag);
    exp_t x;
    x.tag   = tag;
    x.dout  = 8'h00;
    x.full  = 1'b0;
    x.empty = 1'b1;
    x.ovf   = 1'b0;
    x.udf   = 1'b0;
    x.cnt   = 6'd0;
    return x;
  endfunction

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    wr         = 1'b0;
    rd         = 1'b0;
    data_in    = 8'h00;

    #2;
    checkOutput(resetExp("reset_initial"));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Fill with 0..31; full only after the 32nd write.
    for (int i = 0; i < 32; i++) begin
      applyStimulus("fill", 1'b1, 1'b0, 8'(i), 8'h00, (i == 31), 1'b0, 1'b0, 1'b0, 6'(i + 1));
    end
    // Write while full is rejected, then the pulse drops.
    applyStimulus("overflow_write", 1'b1, 1'b0, 8'd32, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 6'd32);
    applyStimulus("overflow_clear", 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 6'd32);

    // Drain: 0..31 in order, nothing from the rejected write.
    for (int i = 0; i < 32; i++) begin
      applyStimulus("drain", 1'b0, 1'b1, 8'h00, 8'(i), 1'b0, (i == 31), 1'b0, 1'b0, 6'(31 - i));
    end
    applyStimulus("underflow_read", 1'b0, 1'b1, 8'h00, 8'd31, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0);
    applyStimulus("underflow_clear", 1'b0, 1'b0, 8'h00, 8'd31, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);

    // Wrap: move pointers to 20, then fill/drain 32 across the wrap.
    for (int i = 0; i < 20; i++) begin
      applyStimulus("wrap_w20", 1'b1, 1'b0, 8'(8'h40 + i), 8'd31, 1'b0, 1'b0, 1'b0, 1'b0, 6'(i + 1));
    end
    for (int i = 0; i < 20; i++) begin
      applyStimulus("wrap_r20", 1'b0, 1'b1, 8'h00, 8'(8'h40 + i), 1'b0, (i == 19), 1'b0, 1'b0, 6'(19 - i));
    end
    for (int i = 0; i < 32; i++) begin
      applyStimulus("wrap_w32", 1'b1, 1'b0, 8'(8'h80 + i), 8'h53, (i == 31), 1'b0, 1'b0, 1'b0, 6'(i + 1));
    end
    for (int i = 0; i < 32; i++) begin
      applyStimulus("wrap_r32", 1'b0, 1'b1, 8'h00, 8'(8'h80 + i), 1'b0, (i == 31), 1'b0, 1'b0, 6'(31 - i));
    end

    // Full + simultaneous rd/wr: oldest word out, 0xAA goes in last.
    for (int i = 0; i < 32; i++) begin
      applyStimulus("sim_fill", 1'b1, 1'b0, 8'(8'hC0 + i), 8'h9F, (i == 31), 1'b0, 1'b0, 1'b0, 6'(i + 1));
    end
    applyStimulus("sim_full_rdwr", 1'b1, 1'b1, 8'hAA, 8'hC0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd32);
    for (int i = 0; i < 31; i++) begin
      applyStimulus("sim_drain", 1'b0, 1'b1, 8'h00, 8'(8'hC1 + i), 1'b0, 1'b0, 1'b0, 1'b0, 6'(31 - i));
    end
    applyStimulus("sim_drain_last", 1'b0, 1'b1, 8'h00, 8'hAA, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);

    // Empty + simultaneous rd/wr: write lands, read rejected, no bypass.
    applyStimulus("sim_empty_rdwr", 1'b1, 1'b1, 8'h55, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 6'd1);
    applyStimulus("sim_empty_read", 1'b0, 1'b1, 8'h00, 8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);

    // Leave some content behind, then reset in the middle of a cycle.
    applyStimulus("pre_reset_w1", 1'b1, 1'b0, 8'h11, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1);
    applyStimulus("pre_reset_w2", 1'b1, 1'b0, 8'h22, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 6'd2);
    applyStimulus("pre_reset_rd", 1'b0, 1'b1, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1);
    applyStimulus("pre_reset_ovfchk", 1'b1, 1'b1, 8'h33, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1);
    applyStimulus("pre_reset_idle", 1'b0, 1'b0, 8'h00, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1);

    // Bounded wait for the monitor to consume everything queued.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL drain_queue: %0d expectations left, required 0", exp_q.size());
      exp_q.delete();
    end

    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput(resetExp("reset_midcycle"));
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Old contents are gone: a fresh write/read returns only the new byte.
    applyStimulus("post_reset_w", 1'b1, 1'b0, 8'h77, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 6'd1);
    applyStimulus("post_reset_r", 1'b0, 1'b1, 8'h00, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);
    applyStimulus("post_reset_r2", 1'b0, 1'b1, 8'h00, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1, 6'd0);
    applyStimulus("post_reset_idle", 1'b0, 1'b0, 8'h00, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL final_queue: %0d expectations left, required 0", exp_q.size());
    end
    @(posedge clk);
    #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
